disp_pixel_fifo: RTL and testbench
==================================

Name: disp_pixel_fifo

Overview:
- Single-clock, parametrised display pixel buffer for the display pipeline.
- Accepts packed multi-pixel words from the frame fetch side and stores them in an internal FIFO of DEPTH words.
- Unpacks one pixel per DSP_preDE cycle and emits registered R/G/B with DSP_DE aligned to the data.
- Adds capabilities the previous generation lacked: pixel-count/width generalisation, selectable lane order, sticky overflow/underflow flags, occupancy output, DE/data alignment, and a synchronous FIFO clear.

Parameters:
- COMP_W, 8, bits per colour component; legal range 5..10; PIX_W = 3*COMP_W.
- PIX_PER_WORD, 2, pixels per input word; legal range 1..8; each pixel occupies a 32-bit lane, with the pixel in the low PIX_W bits.
- DEPTH, 512, FIFO depth in words; power of two, at least 4.
- WREADY_TH, 256, minimum free words for BUF_WREADY = 1; legal range 1..DEPTH.

Ports:
- DCLK  in  1  pixel/system clock
- DRST_N  in  1  reset, asynchronous, active-low
- FIFORST  in  1  synchronous FIFO clear
- DISPON  in  1  display enable; 0 forces black output
- LANE_ORDER  in  1  0: lane 0 (LSB lane) first; 1: highest lane first
- FIFOIN  in  32*PIX_PER_WORD  packed input word
- FIFOWR  in  1  write strobe
- DSP_preDE  in  1  pixel request (one pixel per cycle)
- BUF_WREADY  out  1  free words >= WREADY_TH
- BUF_COUNT  out  clog2(DEPTH)+1  stored words
- BUF_OVER  out  1  sticky overflow
- BUF_UNDER  out  1  sticky underflow
- DSP_R, DSP_G, DSP_B  out  COMP_W each  pixel components
- DSP_DE  out  1  data enable aligned to DSP_R/G/B

Behaviour:
- Reset (DRST_N = 0, asynchronous):
  - FIFO empty, lane counter 0, BUF_COUNT 0, BUF_WREADY 1.
  - BUF_OVER 0, BUF_UNDER 0, DSP_R/G/B 0, DSP_DE 0.
- FIFORST = 1 (sampled on DCLK):
  - Same cleared state as reset, except DSP_DE takes the registered DSP_preDE value.
  - Overrides any same-cycle write or read.
- Write:
  - Occurs when FIFOWR = 1 and BUF_COUNT < DEPTH, using BUF_COUNT at the start of the cycle.
  - The stored word keeps only bits [PIX_W-1:0] of each 32-bit lane.
  - A write at full is dropped and sets BUF_OVER, even if a pop happens in the same cycle.
- Read / unpack:
  - A lane counter selects the pixel within the head word.
  - When DSP_preDE = 1 and the FIFO is non-empty, the selected pixel is issued and the counter advances.
  - On the last lane (index PIX_PER_WORD-1 in issue order), the head word is popped and the counter returns to 0.
  - Lane-to-pixel mapping for index k:
    - LANE_ORDER = 0: lane k.
    - LANE_ORDER = 1: lane PIX_PER_WORD-1-k.
  - LANE_ORDER is sampled only when the counter is 0 (word boundary); it is held for the rest of the word.
- Underflow:
  - DSP_preDE = 1 with the FIFO empty sets BUF_UNDER and issues pixel 0.
  - The counter does not advance.
  - No write-to-read bypass: a write in the same cycle is not visible to that read.
- Output timing (latency 1 cycle):
  - DSP_DE(n+1) = DSP_preDE(n).
  - DSP_R/G/B(n+1) hold the pixel issued at n.
  - With DSP_preDE = 0, DSP_R/G/B hold their previous value.
  - DISPON = 0 loads 0 into DSP_R/G/B whenever they would update; FIFO consumption continues unchanged so raster sync is preserved.
- Component mapping of a pixel: R = [PIX_W-1:2*COMP_W], G = [2*COMP_W-1:COMP_W], B = [COMP_W-1:0].
- Count and flags:
  - BUF_COUNT is registered and changes by +1, -1 or 0 per cycle. A simultaneous accepted write and pop leaves it unchanged.
  - BUF_WREADY is registered from the next-state count: (DEPTH - count_next) >= WREADY_TH.
  - Sticky flags clear only on reset or FIFORST.
- Pointers are clog2(DEPTH) bits and wrap naturally. Full/empty are derived from the count, never from pointer equality alone.

Test Plan:
- PIX_PER_WORD = 2, write 0x00A1B2C3_00112233, LANE_ORDER = 0, preDE pulsed for 2 cycles:
  - DSP_DE high 1 cycle later; RGB = 11/22/33, then A1/B2/C3; BUF_COUNT 1 -> 0 after the second pixel.
- Same word with LANE_ORDER = 1:
  - Output A1B2C3 first, then 112233.
  - Toggle LANE_ORDER between the two pixels: order is unchanged for that word.
- Fill DEPTH = 4 FIFO with 4 words, then a 5th FIFOWR alongside a last-lane pop:
  - The 5th word is dropped, BUF_OVER = 1, BUF_COUNT = 3.
  - Subsequent reads return the original 4 words in order.
- Empty FIFO, preDE = 1 together with FIFOWR:
  - BUF_UNDER = 1, RGB = 0.
  - On the next preDE, the written pixel appears; the count is correct.
- DISPON = 0 while streaming 8 pixels:
  - RGB = 0 throughout, DE still follows preDE, 4 words consumed.
  - Re-assert DISPON: the next pixel is the 9th.
- Assert DRST_N low mid-word, then FIFORST high with 3 words stored:
  - Both give BUF_COUNT 0, BUF_WREADY 1, flags 0, RGB 0.
  - The first subsequent read starts at lane 0 of newly written data.

Source files
------------

// File: rtl/disp_pixel_fifo_if.sv
// Signal bundle for the display pixel buffer: frame-fetch write side, display
// read side, and the status/control lines. The bench drives the master side.
interface disp_pixel_fifo_if #(
    parameter int COMP_W       = 8,
    parameter int PIX_PER_WORD = 2,
    parameter int DEPTH        = 512
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Handshake: a word is accepted on any DCLK edge where FIFOWR = 1 and the
    // buffer is not full; BUF_WREADY is advisory back-pressure only. A pixel is
    // consumed on any edge where DSP_preDE = 1 and the buffer is non-empty.
    logic                      FIFORST;
    logic                      DISPON;
    logic                      LANE_ORDER;
    logic [32*PIX_PER_WORD-1:0] FIFOIN;
    logic                      FIFOWR;
    logic                      DSP_preDE;
    logic                      BUF_WREADY;
    logic [CNT_W-1:0]          BUF_COUNT;
    logic                      BUF_OVER;
    logic                      BUF_UNDER;
    logic [COMP_W-1:0]         DSP_R;
    logic [COMP_W-1:0]         DSP_G;
    logic [COMP_W-1:0]         DSP_B;
    logic                      DSP_DE;

    modport master (
        output FIFORST, DISPON, LANE_ORDER, FIFOIN, FIFOWR, DSP_preDE,
        input  BUF_WREADY, BUF_COUNT, BUF_OVER, BUF_UNDER,
        input  DSP_R, DSP_G, DSP_B, DSP_DE
    );

    modport slave (
        input  FIFORST, DISPON, LANE_ORDER, FIFOIN, FIFOWR, DSP_preDE,
        output BUF_WREADY, BUF_COUNT, BUF_OVER, BUF_UNDER,
        output DSP_R, DSP_G, DSP_B, DSP_DE
    );
endinterface

// File: rtl/disp_pixel_fifo.sv
// Display pixel buffer: stores packed multi-pixel words and unpacks one pixel
// per DSP_preDE cycle into registered R/G/B with DSP_DE aligned to the data.
module disp_pixel_fifo #(
    parameter int COMP_W       = 8,
    parameter int PIX_PER_WORD = 2,
    parameter int DEPTH        = 512,
    parameter int WREADY_TH    = 256
) (
    input logic              DCLK,
    input logic              DRST_N,
    disp_pixel_fifo_if.slave bus
);
    localparam int PIX_W  = 3 * COMP_W;
    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  TH_C      = CNT_W'(WREADY_TH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);

    logic [WORD_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              order_q, order_d;
    logic              wready_q, wready_d;
    logic              over_q, under_q;
    logic [COMP_W-1:0] r_q, g_q, b_q;
    logic              de_q;

    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] head;
    logic [PIX_W-1:0]  head_pix [PIX_PER_WORD];
    logic [PIX_W-1:0]  issue_pix;
    logic [LANE_W-1:0] phys_lane;
    logic              full, empty, wr_en, rd_en, last_lane, pop, order_eff;

    always_comb begin
        wdata = '0;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            wdata[i*PIX_W +: PIX_W] = bus.FIFOIN[i*32 +: PIX_W];
        end
        head = mem_q[rd_ptr_q];
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            head_pix[i] = head[i*PIX_W +: PIX_W];
        end

        full  = (count_q == DEPTH_C);
        empty = (count_q == '0);
        wr_en = bus.FIFOWR && !full && !bus.FIFORST;
        rd_en = bus.DSP_preDE && !empty && !bus.FIFORST;

        // Lane order is latched at the word boundary and held for the whole word.
        order_eff = (lane_q == '0) ? bus.LANE_ORDER : order_q;
        order_d   = order_eff;
        phys_lane = order_eff ? (LAST_LANE - lane_q) : lane_q;
        last_lane = (lane_q == LAST_LANE);
        pop       = rd_en && last_lane;
        issue_pix = rd_en ? head_pix[phys_lane] : '0;

        lane_d = lane_q;
        if (rd_en) begin
            lane_d = last_lane ? '0 : lane_q + LANE_W'(1);
        end

        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        wready_d = ((DEPTH_C - count_d) >= TH_C);
    end

    // Storage has no reset; validity is tracked entirely by the count.
    always_ff @(posedge DCLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge DCLK or negedge DRST_N) begin
        if (!DRST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            lane_q   <= '0;
            order_q  <= 1'b0;
            wready_q <= 1'b1;
            over_q   <= 1'b0;
            under_q  <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            de_q     <= 1'b0;
        end else if (bus.FIFORST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            lane_q   <= '0;
            order_q  <= 1'b0;
            wready_q <= 1'b1;
            over_q   <= 1'b0;
            under_q  <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            de_q     <= bus.DSP_preDE;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q  <= count_d;
            lane_q   <= lane_d;
            order_q  <= order_d;
            wready_q <= wready_d;
            if (bus.FIFOWR && full) begin
                over_q <= 1'b1;
            end
            if (bus.DSP_preDE && empty) begin
                under_q <= 1'b1;
            end
            de_q <= bus.DSP_preDE;
            // Blanking only masks the data; consumption still tracks preDE.
            if (bus.DSP_preDE) begin
                r_q <= bus.DISPON ? issue_pix[PIX_W-1:2*COMP_W]      : '0;
                g_q <= bus.DISPON ? issue_pix[2*COMP_W-1:COMP_W]     : '0;
                b_q <= bus.DISPON ? issue_pix[COMP_W-1:0]            : '0;
            end
        end
    end

    assign bus.BUF_WREADY = wready_q;
    assign bus.BUF_COUNT  = count_q;
    assign bus.BUF_OVER   = over_q;
    assign bus.BUF_UNDER  = under_q;
    assign bus.DSP_R      = r_q;
    assign bus.DSP_G      = g_q;
    assign bus.DSP_B      = b_q;
    assign bus.DSP_DE     = de_q;
endmodule

// File: tb/tb_disp_pixel_fifo.sv
// Bench for disp_pixel_fifo: directed scenarios then random traffic, all
// outputs compared every cycle against a word-queue reference model.
module tb_disp_pixel_fifo;
    localparam int COMP_W = 8;
    localparam int P      = 2;
    localparam int DEPTH  = 4;
    localparam int TH     = 2;
    localparam int W      = 32 * P;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    disp_pixel_fifo_if #(.COMP_W(COMP_W), .PIX_PER_WORD(P), .DEPTH(DEPTH)) bus ();

    disp_pixel_fifo #(
        .COMP_W(COMP_W), .PIX_PER_WORD(P), .DEPTH(DEPTH), .WREADY_TH(TH)
    ) dut (
        .DCLK   (clk),
        .DRST_N (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of stored words, each an array of P pixels.
    logic [23:0] m_q [$][P];
    int          m_lane;
    bit          m_held;
    bit          m_over, m_under, m_de;
    logic [23:0] m_rgb;

    task automatic model_clear(input bit de);
        m_q.delete();
        m_lane  = 0;
        m_held  = 0;
        m_over  = 0;
        m_under = 0;
        m_rgb   = '0;
        m_de    = de;
    endtask

    task automatic model_step(input bit wr, input logic [W-1:0] din, input bit pre,
                              input bit dis, input bit lo, input bit frst);
        logic [23:0] word [P];
        logic [23:0] pix;
        bit          ord;
        int          depth_now;
        if (frst) begin
            model_clear(pre);
            return;
        end
        depth_now = m_q.size();
        pix = '0;
        if (pre) begin
            if (depth_now == 0) begin
                m_under = 1;
            end else begin
                ord = (m_lane == 0) ? lo : m_held;
                m_held = ord;
                pix = m_q[0][ord ? (P - 1 - m_lane) : m_lane];
                m_lane++;
                if (m_lane == P) begin
                    m_lane = 0;
                    void'(m_q.pop_front());
                end
            end
            m_rgb = dis ? pix : 24'h0;
        end else if (m_lane == 0) begin
            m_held = lo;
        end
        if (wr) begin
            if (depth_now == DEPTH) begin
                m_over = 1;
            end else begin
                for (int i = 0; i < P; i++) word[i] = din[i*32 +: 24];
                m_q.push_back(word);
            end
        end
        m_de = pre;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count",  32'(bus.BUF_COUNT), 32'(m_q.size()));
        chk("wready", 32'(bus.BUF_WREADY), 32'((DEPTH - m_q.size()) >= TH));
        chk("over",   32'(bus.BUF_OVER),  32'(m_over));
        chk("under",  32'(bus.BUF_UNDER), 32'(m_under));
        chk("de",     32'(bus.DSP_DE),    32'(m_de));
        chk("rgb",    {8'h0, bus.DSP_R, bus.DSP_G, bus.DSP_B}, {8'h0, m_rgb});
    endtask

    task automatic cycle(input bit wr, input logic [W-1:0] din, input bit pre,
                         input bit dis, input bit lo, input bit frst);
        @(negedge clk);
        bus.FIFOWR     = wr;
        bus.FIFOIN     = din;
        bus.DSP_preDE  = pre;
        bus.DISPON     = dis;
        bus.LANE_ORDER = lo;
        bus.FIFORST    = frst;
        @(posedge clk);
        model_step(wr, din, pre, dis, lo, frst);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.FIFOWR = 0; bus.DSP_preDE = 0; bus.FIFORST = 0;
        rst_n = 1'b0;
        #1;
        model_clear(0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    logic [W-1:0] w5;
    logic [W-1:0] wn;

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b1;
        bus.FIFORST = 0; bus.DISPON = 1; bus.LANE_ORDER = 0;
        bus.FIFOIN = '0; bus.FIFOWR = 0; bus.DSP_preDE = 0;
        model_clear(0);
        #2 rst_n = 1'b0;
        #1 check_all();
        #10 rst_n = 1'b1;

        // Basic two-lane unpack, lane 0 first.
        cycle(1, 64'h00A1B2C3_00112233, 0, 1, 0, 0);
        chk("t1_count_after_wr", 32'(bus.BUF_COUNT), 1);
        cycle(0, '0, 1, 1, 0, 0);
        chk("t1_pix0", {8'h0, bus.DSP_R, bus.DSP_G, bus.DSP_B}, 32'h112233);
        chk("t1_de", 32'(bus.DSP_DE), 1);
        cycle(0, '0, 1, 1, 0, 0);
        chk("t1_pix1", {8'h0, bus.DSP_R, bus.DSP_G, bus.DSP_B}, 32'hA1B2C3);
        chk("t1_count_empty", 32'(bus.BUF_COUNT), 0);
        cycle(0, '0, 0, 1, 0, 0);
        chk("t1_hold", {8'h0, bus.DSP_R, bus.DSP_G, bus.DSP_B}, 32'hA1B2C3);

        // Reversed lane order, toggled mid-word.
        cycle(1, 64'hFFA1B2C3_EE112233, 0, 1, 1, 0);
        cycle(0, '0, 1, 1, 1, 0);
        chk("t2_pix0", {8'h0, bus.DSP_R, bus.DSP_G, bus.DSP_B}, 32'hA1B2C3);
        cycle(0, '0, 1, 1, 0, 0);
        chk("t2_pix1", {8'h0, bus.DSP_R, bus.DSP_G, bus.DSP_B}, 32'h112233);

        // Fill, then a write at full alongside a last-lane pop.
        for (int i = 0; i < DEPTH; i++) cycle(1, rnd_word(), 0, 1, 0, 0);
        chk("t3_full_wready", 32'(bus.BUF_WREADY), 0);
        cycle(0, '0, 1, 1, 0, 0);
        cycle(1, rnd_word(), 1, 1, 0, 0);
        chk("t3_over", 32'(bus.BUF_OVER), 1);
        chk("t3_count", 32'(bus.BUF_COUNT), 3);
        for (int i = 0; i < 6; i++) cycle(0, '0, 1, 1, $urandom_range(0, 1), 0);

        // Underflow with a same-cycle write; no bypass.
        cycle(1, 64'h00445566_00778899, 1, 1, 0, 0);
        chk("t4_under", 32'(bus.BUF_UNDER), 1);
        chk("t4_rgb0", {8'h0, bus.DSP_R, bus.DSP_G, bus.DSP_B}, 0);
        cycle(0, '0, 1, 1, 0, 0);
        chk("t4_pix", {8'h0, bus.DSP_R, bus.DSP_G, bus.DSP_B}, 32'h778899);
        cycle(0, '0, 1, 1, 0, 0);

        // Blanked streaming of 8 pixels; a fifth word arrives mid-stream.
        for (int i = 0; i < DEPTH; i++) cycle(1, rnd_word(), 0, 1, 0, 0);
        w5 = rnd_word();
        for (int i = 0; i < 8; i++) cycle(i == 2, w5, 1, 0, 0, 0);
        chk("t5_count", 32'(bus.BUF_COUNT), 1);
        cycle(0, '0, 1, 1, 0, 0);
        chk("t5_ninth", {8'h0, bus.DSP_R, bus.DSP_G, bus.DSP_B}, {8'h0, w5[23:0]});
        cycle(0, '0, 1, 1, 0, 0);

        // Async reset mid-word, then synchronous clear with 3 words stored.
        cycle(1, rnd_word(), 0, 1, 0, 0);
        cycle(0, '0, 1, 1, 0, 0);
        do_reset();
        chk("t6_rst_count", 32'(bus.BUF_COUNT), 0);
        wn = rnd_word();
        cycle(1, wn, 0, 1, 0, 0);
        cycle(0, '0, 1, 1, 0, 0);
        chk("t6_rst_lane0", {8'h0, bus.DSP_R, bus.DSP_G, bus.DSP_B}, {8'h0, wn[23:0]});
        for (int i = 0; i < 3; i++) cycle(1, rnd_word(), 0, 1, 0, 0);
        cycle(1, rnd_word(), 1, 1, 0, 1);
        chk("t6_clr_count", 32'(bus.BUF_COUNT), 0);
        chk("t6_clr_wready", 32'(bus.BUF_WREADY), 1);
        wn = rnd_word();
        cycle(1, wn, 0, 1, 0, 0);
        cycle(0, '0, 1, 1, 0, 0);
        chk("t6_clr_lane0", {8'h0, bus.DSP_R, bus.DSP_G, bus.DSP_B}, {8'h0, wn[23:0]});

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 35, rnd_word(), $urandom_range(0, 99) < 65,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 63) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
